// File: rtl/div_pkg.sv
// Shared definitions for the subtract-shift divider.
//   state_e    : controller states (IDLE, LOAD, RUN, FIX, DONE)
//   iter_count : number of RUN cycles for a given width / steps-per-cycle
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int iter_count(input int data_w, input int steps_per_cycle);
    return data_w / steps_per_cycle;
  endfunction

endpackage

// File: rtl/div_subshift_step.sv
// One combinational restoring division step.
//   rem_i     : partial remainder (DATA_W+1 bits, always < divisor)
//   quo_i     : dividend bits still to consume (MSBs) / quotient bits so far (LSBs)
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the trial subtract
//   quo_o     : quo_i shifted left by one with the new quotient bit in the LSB
module div_subshift_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;
  logic              rem_top_unused;

  // The incoming remainder is always below the divisor, so its top bit is
  // zero; it only exists so the shifted value below cannot overflow.
  assign rem_top_unused = rem_i[DATA_W];

  always_comb begin
    // NOTE: every combinational output gets a value on every path; the
    // defaults first make that true and prevent latch inference.
    rem_o   = '0;
    quo_o   = '0;
    shifted = {rem_i[DATA_W-1:0], quo_i[DATA_W-1]};
    // One extra bit so the borrow shows up as the sign of the difference.
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    if (!diff[DATA_W+1]) begin
      rem_o = diff[DATA_W:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_subshift_hs.sv
// Iterative restoring divider with valid/ready handshakes on both sides.
// Optional feature macro: DIV_SIGNED_EN (two's-complement signed division
// when defined; otherwise the sign input is ignored and all operations are
// unsigned, with identical latency).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   sign                  : 1 = signed division (DIV_SIGNED_EN builds only)
//   dividend, divisor     : operands
//   out_valid / out_ready : result handshake (results held while in DONE)
//   quotient, remainder   : results
//   div_by_zero           : result came from a zero divisor
module div_subshift_hs
  import div_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int N     = iter_count(DATA_W, STEPS_PER_CYCLE);
  localparam int CNT_W = $clog2(N + 1);

  if (DATA_W < 4 || (DATA_W % 2) != 0) begin : g_bad_width
    $error("div_subshift_hs: DATA_W must be even and >= 4");
  end
  if (STEPS_PER_CYCLE < 1 || (DATA_W % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
    $error("div_subshift_hs: STEPS_PER_CYCLE must divide DATA_W");
  end

  logic sign_en;
`ifdef DIV_SIGNED_EN
  assign sign_en = sign;
`else
  logic sign_unused;
  assign sign_unused = sign;
  assign sign_en     = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;          // dividend, then quotient, shift register
  logic [DATA_W-1:0] b_q, b_d;          // divisor magnitude
  logic [DATA_W:0]   acc_q, acc_d;      // partial remainder accumulator
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rmd_q, rmd_d;
  logic              dbz_q, dbz_d;

  logic [DATA_W:0]   acc_run;
  logic [DATA_W-1:0] a_run;

  // Chain of STEPS_PER_CYCLE restoring steps, MSB first.
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    logic [DATA_W:0]   rem_in, rem_out;
    logic [DATA_W-1:0] quo_in, quo_out;
    if (g == 0) begin : g_first
      assign rem_in = acc_q;
      assign quo_in = a_q;
    end else begin : g_next
      assign rem_in = g_step[g-1].rem_out;
      assign quo_in = g_step[g-1].quo_out;
    end
    div_subshift_step #(.DATA_W(DATA_W)) u_step (
      .rem_i     (rem_in),
      .quo_i     (quo_in),
      .divisor_i (b_q),
      .rem_o     (rem_out),
      .quo_o     (quo_out)
    );
  end

  assign acc_run = g_step[STEPS_PER_CYCLE-1].rem_out;
  assign a_run   = g_step[STEPS_PER_CYCLE-1].quo_out;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sign_d  = sign_en;
          a_d     = dividend;
          b_d     = divisor;
          state_d = LOAD;
        end
      end
      LOAD: begin
        q_neg_d = sign_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        r_neg_d = sign_q & a_q[DATA_W-1];
        if (sign_q && a_q[DATA_W-1]) a_d = -a_q;
        if (sign_q && b_q[DATA_W-1]) b_d = -b_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d   = a_run;
        acc_d = acc_run;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves all ones in the quotient and |dividend| in
        // the accumulator; skipping the quotient negation keeps all ones,
        // and the remainder negation restores the original dividend.
        dbz_d   = (b_q == '0);
        quo_d   = (q_neg_q && b_q != '0) ? -a_q : a_q;
        rmd_d   = r_neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/div_subshift_hs.md
DIV_SUBSHIFT_HS -- requirements
Module: div_subshift_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width; even, >= 4.
REQ-002 SHALL have parameter STEPS_PER_CYCLE, default 1: quotient bits resolved per clock; must divide DATA_W.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands and sign valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port sign, input, 1: 1 = two's-complement signed division, 0 = unsigned.
REQ-008 SHALL have ports dividend and divisor, input, DATA_W each: operands.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have ports quotient and remainder, output, DATA_W each: results.
REQ-012 SHALL have port div_by_zero, output, 1: current result came from a zero divisor.

Function
REQ-013 SHALL use states IDLE, LOAD, RUN, FIX, DONE; N = DATA_W/STEPS_PER_CYCLE.
REQ-014 IDLE: in_ready=1; in_valid&&in_ready at an edge captures sign, dividend, divisor and moves to LOAD.
REQ-015 LOAD (1 cycle): signed mode takes operand magnitudes and records quotient/remainder signs; clears remainder accumulator.
REQ-016 RUN (exactly N cycles): each cycle performs STEPS_PER_CYCLE restoring subtract-shift steps, MSB first.
REQ-017 FIX (1 cycle): negates quotient if operand signs differ, negates remainder if dividend negative (signed mode only).
REQ-018 DONE: out_valid=1; quotient/remainder/div_by_zero held stable until out_valid&&out_ready, then IDLE.
REQ-019 Latency: out_valid SHALL rise exactly N+2 cycles after the accepting edge.
REQ-020 in_ready SHALL be 0 in all states except IDLE; inputs ignored outside IDLE.
REQ-021 Quotient SHALL truncate toward zero; remainder takes the dividend's sign; dividend = quotient*divisor + remainder.
REQ-022 Divisor 0: quotient = all ones, remainder = dividend, div_by_zero=1, same latency.
REQ-023 Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0, div_by_zero=0.
REQ-024 Internal remainder accumulator SHALL be DATA_W+1 bits so no step overflows.

Reset
REQ-025 rst SHALL force IDLE on the next edge from any state, aborting any operation in flight.
REQ-026 After reset: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
REQ-027 rst SHALL take priority over in_valid and out_ready asserted in the same cycle.

Configuration
REQ-028 Macro DIV_SIGNED_EN defined: signed support per REQ-015/017/021/023.
REQ-029 Macro DIV_SIGNED_EN undefined: sign input ignored, all operations unsigned, FIX still occupies 1 cycle (latency unchanged).

Structure
REQ-030 Package div_pkg SHALL hold the state enum and the iteration-count function (DATA_W/STEPS_PER_CYCLE).
REQ-031 Sub-module div_subshift_step SHALL implement one combinational restoring step (shift-in bit, trial subtract, quotient bit); instantiated STEPS_PER_CYCLE times in a chain.
REQ-032 Parameter legality (REQ-001/002) SHALL be checked at elaboration.

Verification (DATA_W=32 unless stated)
REQ-033 Unsigned 100/7 -> quotient 14, remainder 2, out_valid exactly 34 cycles after accept.
REQ-034 Signed (DIV_SIGNED_EN) -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1; following 9/3 -> div_by_zero=0, quotient 3.
REQ-036 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> in_ready=1 next cycle.
REQ-037 rst asserted during RUN cycle 10 -> next cycle in_ready=1, out_valid=0, outputs 0; new 20/4 then yields 5 rem 0.
REQ-038 STEPS_PER_CYCLE=4, 1000/33 -> quotient 30, remainder 10, latency 10 cycles; 200 random operand pairs match the reference model for both parameter sets.
